fft_frame_scheduler: RTL and testbench

- Sits between the audio sample stream and fft_top, and sequences every FFT run.
- Collects incoming 24-bit samples into two ping-pong frame banks and starts fft_top when a bank is full.
- Serves fft_top's buffer reads from the full bank.
- Watches the magnitude output stream and reports the peak bin per frame; flags overruns and start timeouts.

---
 rtl/fft_frame_scheduler.sv | 171 +++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame buffer and run sequencer in front of fft_top.
// Collects samples into two banks, starts an FFT on each full bank, serves
// its buffer reads and reports the per-frame peak magnitude bin.
module fft_frame_scheduler #(
  parameter int unsigned N_POINTS      = 512,
  parameter int unsigned ADDR_W        = 9,
  parameter int unsigned DATA_W        = 24,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_fft_data_ready,
  input  logic [ADDR_W-1:0] i_fft_read_addr,
  output logic [DATA_W-1:0] o_fft_data,
  input  logic              i_fft_busy,
  input  logic              i_fft_mag_valid,
  input  logic [ADDR_W-1:0] i_fft_mag_addr,
  input  logic [DATA_W-1:0] i_fft_mag,
  input  logic              i_fft_done,
  output logic [ADDR_W-1:0] o_peak_bin,
  output logic [DATA_W-1:0] o_peak_mag,
  output logic              o_result_valid,
  output logic              o_overrun,
  output logic              o_timeout,
  output logic [15:0]       o_frame_count
);

  localparam int unsigned TMR_W       = $clog2(START_TIMEOUT + 1);
  localparam int unsigned HALF_POINTS = N_POINTS / 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [0:2*N_POINTS-1];
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        bank_full;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] run_max;
  logic [ADDR_W-1:0] run_bin;

  logic [1:0]        release_c;
  logic [1:0]        full_rel_c;
  logic              start_expire_c;
  logic              run_finish_c;
  logic              tgt_bank_c;
  logic              wr_en_c;
  logic              wr_last_c;
  logic              drop_c;
  logic              mag_in_range_c;
  logic              peak_hit_c;
  logic [DATA_W-1:0] nxt_max_c;
  logic [ADDR_W-1:0] nxt_bin_c;

  // Bank release by the sequencer: start timeout or end of an FFT run.
  always_comb begin
    release_c      = 2'b00;
    start_expire_c = (state == S_START) && !i_fft_busy &&
                     (timer == TMR_W'(START_TIMEOUT - 1));
    run_finish_c   = (state == S_RUN) && i_fft_done;
    if (start_expire_c || run_finish_c) release_c[rd_bank] = 1'b1;
  end

  // Write target selection; a release in this cycle frees its bank before the write is judged.
  always_comb begin
    full_rel_c = bank_full & ~release_c;
    tgt_bank_c = wr_bank;
    if (full_rel_c[wr_bank] && !full_rel_c[~wr_bank]) tgt_bank_c = ~wr_bank;
    wr_en_c    = i_sample_valid && !full_rel_c[tgt_bank_c];
    drop_c     = i_sample_valid && full_rel_c[tgt_bank_c];
    wr_last_c  = wr_en_c && (wr_ptr == ADDR_W'(N_POINTS - 1));
  end

  // Running peak over bins 1..N/2-1; on equal magnitude the lower bin wins.
  always_comb begin
    mag_in_range_c = (i_fft_mag_addr != '0) && (i_fft_mag_addr < ADDR_W'(HALF_POINTS));
    peak_hit_c     = (state == S_RUN) && i_fft_mag_valid && mag_in_range_c &&
                     ((i_fft_mag > run_max) ||
                      ((i_fft_mag == run_max) && (i_fft_mag_addr < run_bin)));
    nxt_max_c      = peak_hit_c ? i_fft_mag      : run_max;
    nxt_bin_c      = peak_hit_c ? i_fft_mag_addr : run_bin;
  end

  // Frame bank storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_c) mem[{tgt_bank_c, wr_ptr}] <= i_sample;
  end

  // fft_top reads the bank currently latched for the run.
  assign o_fft_data = mem[{rd_bank, i_fft_read_addr}];

  // Write pointer, bank occupancy and overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      wr_ptr    <= '0;
      bank_full <= 2'b00;
      o_overrun <= 1'b0;
    end else begin
      bank_full <= full_rel_c;
      wr_bank   <= tgt_bank_c;
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_last_c) begin
          bank_full[tgt_bank_c] <= 1'b1;
          if (!full_rel_c[~tgt_bank_c]) wr_bank <= ~tgt_bank_c;
        end
      end
      if (drop_c) o_overrun <= 1'b1;
    end
  end

  // Run sequencer: pick a full bank, hand it to fft_top, collect the peak.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      rd_bank          <= 1'b0;
      timer            <= '0;
      run_max          <= '0;
      run_bin          <= '0;
      o_fft_data_ready <= 1'b0;
      o_peak_bin       <= '0;
      o_peak_mag       <= '0;
      o_result_valid   <= 1'b0;
      o_timeout        <= 1'b0;
      o_frame_count    <= '0;
    end else begin
      o_result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bank_full) begin
            rd_bank          <= (&bank_full) ? ~wr_bank : ~bank_full[0];
            timer            <= '0;
            o_fft_data_ready <= 1'b1;
            state            <= S_START;
          end
        end
        S_START: begin
          if (i_fft_busy) begin
            o_fft_data_ready <= 1'b0;
            run_max          <= '0;
            run_bin          <= '0;
            state            <= S_RUN;
          end else if (start_expire_c) begin
            o_fft_data_ready <= 1'b0;
            o_timeout        <= 1'b1;
            state            <= S_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_RUN: begin
          run_max <= nxt_max_c;
          run_bin <= nxt_bin_c;
          if (i_fft_done) begin
            o_peak_bin     <= nxt_bin_c;
            o_peak_mag     <= nxt_max_c;
            o_result_valid <= 1'b1;
            o_frame_count  <= o_frame_count + 16'd1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler with a behavioural fft_top stand-in.
module tb_fft_frame_scheduler;

  localparam int unsigned N  = 512;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 24;
  localparam logic [DW-1:0] POS = 24'(10000);
  localparam logic [DW-1:0] NEG = 24'(-10000);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_sample_valid;
  logic [DW-1:0] i_sample;
  logic          o_fft_data_ready;
  logic [AW-1:0] i_fft_read_addr;
  logic [DW-1:0] o_fft_data;
  logic          i_fft_busy;
  logic          i_fft_mag_valid;
  logic [AW-1:0] i_fft_mag_addr;
  logic [DW-1:0] i_fft_mag;
  logic          i_fft_done;
  logic [AW-1:0] o_peak_bin;
  logic [DW-1:0] o_peak_mag;
  logic          o_result_valid;
  logic          o_overrun;
  logic          o_timeout;
  logic [15:0]   o_frame_count;

  typedef struct {
    int bin;
    int mag;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   rv_pulses  = 0;
  int   sidx       = 0;
  int   exp_frames = 0;
  int   waited;

  fft_frame_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .i_sample_valid   (i_sample_valid),
    .i_sample         (i_sample),
    .o_fft_data_ready (o_fft_data_ready),
    .i_fft_read_addr  (i_fft_read_addr),
    .o_fft_data       (o_fft_data),
    .i_fft_busy       (i_fft_busy),
    .i_fft_mag_valid  (i_fft_mag_valid),
    .i_fft_mag_addr   (i_fft_mag_addr),
    .i_fft_mag        (i_fft_mag),
    .i_fft_done       (i_fft_done),
    .o_peak_bin       (o_peak_bin),
    .o_peak_mag       (o_peak_mag),
    .o_result_valid   (o_result_valid),
    .o_overrun        (o_overrun),
    .o_timeout        (o_timeout),
    .o_frame_count    (o_frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [DW-1:0] sample_val(input int idx);
    return ((idx % N) < (N / 2)) ? POS : NEG;
  endfunction

  function automatic logic [DW-1:0] mag_of(input int pat, input int a);
    case (pat)
      0:       return (a == 5) ? 24'd900 : (a == 0) ? 24'd5000 : (a == 300) ? 24'd9999 : 24'd10;
      1:       return (a == 7 || a == 12) ? 24'd500 : 24'd10;
      default: return (a == 255) ? 24'd7777 : 24'd10;
    endcase
  endfunction

  // Scoreboard side: every result pulse must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (o_result_valid) begin
        rv_pulses++;
        if (exp_q.size() == 0) begin
          check_val("rv_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("peak_bin", 32'(o_peak_bin), e.bin);
          check_val("peak_mag", 32'(o_peak_mag), e.mag);
          check_val("frame_cnt_at_rv", 32'(o_frame_count), e.cnt);
        end
      end
    end
  end

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      i_sample_valid = 1'b1;
      i_sample       = sample_val(sidx);
      sidx++;
      @(posedge clk);
      #1;
    end
    i_sample_valid = 1'b0;
  endtask

  task automatic wait_ready(input int bound, output int w);
    w = 0;
    while (!o_fft_data_ready && w < bound) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_val("ready_seen", 32'(o_fft_data_ready), 32'd1);
  endtask

  task automatic read_check(input string tag, input int addr, input logic [DW-1:0] exp);
    i_fft_read_addr = AW'(addr);
    #1;
    check_val(tag, 32'(o_fft_data), 32'(exp));
  endtask

  task automatic raise_busy();
    i_fft_busy = 1'b1;
    @(posedge clk);
    #1;
    check_val("ready_fall", 32'(o_fft_data_ready), 32'd0);
  endtask

  // fft_top stand-in: emits n magnitudes, done on the last one when requested.
  task automatic emit(input int pat, input int n, input bit desc, input bit with_done);
    int            best_bin;
    logic [DW-1:0] best;
    int            p0;
    int            a;
    exp_t          e;
    bit            emitted;
    best_bin = 0;
    best     = '0;
    for (int b = 1; b < N / 2; b++) begin
      emitted = desc ? (b >= N - n) : (b < n);
      if (emitted && mag_of(pat, b) > best) begin
        best     = mag_of(pat, b);
        best_bin = b;
      end
    end
    if (with_done) begin
      exp_frames = (exp_frames + 1) % 65536;
      e.bin = best_bin;
      e.mag = int'(best);
      e.cnt = exp_frames;
      exp_q.push_back(e);
    end
    p0 = rv_pulses;
    for (int k = 0; k < n; k++) begin
      a = desc ? (N - 1 - k) : k;
      i_fft_mag_valid = 1'b1;
      i_fft_mag_addr  = AW'(a);
      i_fft_mag       = mag_of(pat, a);
      i_fft_done      = with_done && (k == n - 1);
      @(posedge clk);
      #1;
    end
    i_fft_mag_valid = 1'b0;
    i_fft_done      = 1'b0;
    if (with_done) begin
      i_fft_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rv_pulse_count", 32'(rv_pulses - p0), 32'd1);
    end
  endtask

  task automatic check_zero_outputs();
    check_val("rst_ready", 32'(o_fft_data_ready), 32'd0);
    check_val("rst_rv", 32'(o_result_valid), 32'd0);
    check_val("rst_overrun", 32'(o_overrun), 32'd0);
    check_val("rst_timeout", 32'(o_timeout), 32'd0);
    check_val("rst_frame_count", 32'(o_frame_count), 32'd0);
    check_val("rst_peak_bin", 32'(o_peak_bin), 32'd0);
    check_val("rst_peak_mag", 32'(o_peak_mag), 32'd0);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    i_sample_valid  = 1'b0;
    i_sample        = '0;
    i_fft_read_addr = '0;
    i_fft_busy      = 1'b0;
    i_fft_mag_valid = 1'b0;
    i_fft_mag_addr  = '0;
    i_fft_mag       = '0;
    i_fft_done      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    sidx       = 0;
    exp_frames = 0;
    exp_q.delete();
    check_zero_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic frame: ready latency, buffer reads, peak with DC and mirror excluded.
    do_reset();
    feed(N);
    wait_ready(5, waited);
    check_val("ready_latency_le2", 32'(waited <= 2), 32'd1);
    read_check("bank0_addr300", 300, NEG);
    read_check("bank0_addr10", 10, POS);
    raise_busy();
    emit(0, N, 1'b0, 1'b1);
    check_val("frame_count_1", 32'(o_frame_count), 32'd1);

    // Tie between bins 7 and 12, magnitudes arriving high bin first.
    feed(N);
    wait_ready(5, waited);
    read_check("bank1_addr300", 300, NEG);
    raise_busy();
    emit(1, N, 1'b1, 1'b1);

    // Magnitude in the same cycle as done, at the top bin of the range.
    feed(N);
    wait_ready(5, waited);
    raise_busy();
    emit(2, N / 2, 1'b0, 1'b1);
    check_val("frame_count_3", 32'(o_frame_count), 32'd3);

    // Start timeout releases the bank; no overrun on sample 1025.
    do_reset();
    feed(N);
    wait_ready(5, waited);
    read_check("to_bank0_addr300", 300, NEG);
    feed(40);
    check_val("timeout_not_early", 32'(o_timeout), 32'd0);
    feed(2 * N + 1 - N - 40);
    check_val("timeout_set", 32'(o_timeout), 32'd1);
    check_val("to_no_overrun", 32'(o_overrun), 32'd0);
    wait_ready(5, waited);
    read_check("to_bank1_addr300", 300, NEG);
    raise_busy();
    emit(0, N, 1'b0, 1'b1);
    check_val("to_frame_count", 32'(o_frame_count), 32'd1);

    // Stalled run: overrun at sample 1025, then bank 1 runs after done.
    do_reset();
    feed(N);
    wait_ready(5, waited);
    raise_busy();
    feed(N);
    check_val("ovr_not_yet", 32'(o_overrun), 32'd0);
    feed(1);
    check_val("ovr_set", 32'(o_overrun), 32'd1);
    feed(N);
    emit(0, N, 1'b0, 1'b1);
    wait_ready(5, waited);
    read_check("ovr_bank1_addr300", 300, NEG);
    read_check("ovr_bank1_addr10", 10, POS);
    raise_busy();
    emit(1, N, 1'b0, 1'b1);
    check_val("ovr_frame_count", 32'(o_frame_count), 32'd2);
    check_val("ovr_sticky", 32'(o_overrun), 32'd1);

    // Reset in the middle of a run, then a clean frame.
    feed(N);
    wait_ready(5, waited);
    raise_busy();
    emit(0, 20, 1'b0, 1'b0);
    reset      = 1'b1;
    i_fft_busy = 1'b0;
    @(posedge clk);
    #1;
    check_zero_outputs();
    reset      = 1'b0;
    sidx       = 0;
    exp_frames = 0;
    feed(N);
    wait_ready(5, waited);
    check_val("post_rst_latency", 32'(waited <= 2), 32'd1);
    raise_busy();
    emit(2, N / 2, 1'b0, 1'b1);
    check_val("post_rst_frame_count", 32'(o_frame_count), 32'd1);
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
